// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 3-stage RV32 pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_MTVEC  = 2'd2,
    PC_MEPC   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CAUSE_NONE   = 4'd0,
    CAUSE_BUSERR = 4'd5,
    CAUSE_IRQ    = 4'd11
  } cause_e;

  // addi x0, x0, 0 is what a flushed pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// MW -> DE operand forwarding compare; x0 is never forwarded.
module fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  input  logic       reg_wr,
  output logic       fwd_a,
  output logic       fwd_b
);

  assign fwd_a = reg_wr && (rd_addr != REG_ZERO) && (rd_addr == rs1_addr);
  assign fwd_b = reg_wr && (rd_addr != REG_ZERO) && (rd_addr == rs2_addr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, PC source,
// data-memory wait sequencing with bus-error timeout, interrupt entry and mret.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addrDE,
  input  logic [4:0] rs2_addrDE,
  input  logic [4:0] rd_addrMW,
  input  logic       reg_wrMW,
  input  logic       rd_enMW,
  input  logic       wr_enMW,
  input  logic       is_mretMW,
  input  logic       dmem_ack,
  input  logic       br_takenDE,
  input  logic       irq_req,
  output logic       stall_IF,
  output logic       stall_MW,
  output logic       flush_DE,
  output logic       flush_MW,
  output logic       fwd_a,
  output logic       fwd_b,
  output logic [1:0] pc_sel,
  output logic       trap_take,
  output logic [3:0] trap_cause
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_e      state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  cause_e           cause_reg, cause_next;

  logic mem_req;
  logic stall;
  logic fwd_a_raw, fwd_b_raw;

  assign mem_req = rd_enMW | wr_enMW;
  assign stall   = ((state_reg == RUN) && mem_req && !dmem_ack) ||
                   ((state_reg == MEM_WAIT) && !dmem_ack);

  fwd_unit u_fwd (
    .rs1_addr (rs1_addrDE),
    .rs2_addr (rs2_addrDE),
    .rd_addr  (rd_addrMW),
    .reg_wr   (reg_wrMW),
    .fwd_a    (fwd_a_raw),
    .fwd_b    (fwd_b_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      cause_reg    <= CAUSE_NONE;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      cause_reg    <= cause_next;
    end
  end

  // wait_cnt counts MEM_WAIT cycles; the RUN request cycle adds one stall cycle
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    cause_next    = cause_reg;
    case (state_reg)
      RUN: begin
        if (mem_req && !dmem_ack) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_W'(1);
        end else if (irq_req && !mem_req) begin
          state_next = TRAP;
          cause_next = CAUSE_IRQ;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == TIMEOUT_CNT) begin
          state_next = TRAP;
          cause_next = CAUSE_BUSERR;
        end else if (wait_cnt_reg < TIMEOUT_CNT) begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      TRAP: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Redirects also apply in the MEM_WAIT ack cycle so a held branch is not lost
  always_comb begin
    stall_IF   = 1'b0;
    stall_MW   = 1'b0;
    flush_DE   = 1'b0;
    flush_MW   = 1'b0;
    fwd_a      = 1'b0;
    fwd_b      = 1'b0;
    pc_sel     = PC_PLUS4;
    trap_take  = 1'b0;
    trap_cause = CAUSE_NONE;
    if (rst_n) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (stall) begin
        stall_IF = 1'b1;
        stall_MW = 1'b1;
      end else if (state_reg == TRAP) begin
        trap_take  = 1'b1;
        trap_cause = cause_reg;
        pc_sel     = PC_MTVEC;
        flush_DE   = 1'b1;
        flush_MW   = 1'b1;
      end else if (is_mretMW) begin
        pc_sel   = PC_MEPC;
        flush_DE = 1'b1;
        flush_MW = 1'b1;
      end else if (br_takenDE) begin
        pc_sel   = PC_BRANCH;
        flush_DE = 1'b1;
      end
    end
  end

endmodule
